// File: rtl/mem_read_arbiter_if.sv
// Shared request/response types and the bundled port interface for mem_read_arbiter.
// The arbiter binds to the slave modport; the requesters and the memory side use master.
package core;
  localparam int peval_width = 3;
endpackage

package sys;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        en;
  } mem_read_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        done;
  } mem_read_rsp_t;

  localparam mem_read_req_t mem_read_req_rst = '0;
  localparam mem_read_rsp_t mem_read_rsp_rst = '0;
endpackage

interface mem_read_arbiter_if #(
  parameter int CH_CNT = core::peval_width,
  parameter int IDX_W  = $clog2(CH_CNT > 1 ? CH_CNT : 2)
);
  sys::mem_read_req_t req_in  [CH_CNT];
  sys::mem_read_rsp_t rsp_out [CH_CNT];
  sys::mem_read_req_t mem_req_out;
  sys::mem_read_rsp_t mem_rsp_in;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;

  modport master (
    output req_in,
    output mem_rsp_in,
    input  rsp_out,
    input  mem_req_out,
    input  grant_idx,
    input  busy
  );

  modport slave (
    input  req_in,
    input  mem_rsp_in,
    output rsp_out,
    output mem_req_out,
    output grant_idx,
    output busy
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// N-channel read arbiter: one outstanding memory read at a time, completion routed to the granted channel.
// Define MEM_READ_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mem_read_arbiter #(
  parameter int CH_CNT = core::peval_width,
  parameter int IDX_W  = $clog2(CH_CNT > 1 ? CH_CNT : 2)
) (
  input logic               clk,
  input logic               rst,
  mem_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic [31:0]      data_q, data_d;
  logic             abandon_q, abandon_d;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [31:0]      win_addr;
  logic [2:0]       win_size;
  logic             granted_en;

`ifdef MEM_READ_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               cand;

  // Search begins one past the last winner and wraps.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_addr = '0;
    win_size = '0;
    cand     = 0;
    for (int k = 0; k < CH_CNT; k++) begin
      cand = (int'(ptr_q) + 1 + k) % CH_CNT;
      if (!found && bus.req_in[cand].en) begin
        found    = 1'b1;
        winner   = IDX_W'(cand);
        win_addr = bus.req_in[cand].addr;
        win_size = bus.req_in[cand].size;
      end
    end
  end
`else
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_addr = '0;
    win_size = '0;
    for (int i = CH_CNT - 1; i >= 0; i--) begin
      if (bus.req_in[i].en) begin
        found    = 1'b1;
        winner   = IDX_W'(i);
        win_addr = bus.req_in[i].addr;
        win_size = bus.req_in[i].size;
      end
    end
  end
`endif

  always_comb begin
    granted_en = 1'b0;
    for (int j = 0; j < CH_CNT; j++) begin
      if (IDX_W'(j) == grant_q) granted_en = bus.req_in[j].en;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    size_d    = size_q;
    data_d    = data_q;
    abandon_d = abandon_q;
`ifdef MEM_READ_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = BUSY;
          grant_d   = winner;
          addr_d    = win_addr;
          size_d    = win_size;
          abandon_d = 1'b0;
`ifdef MEM_READ_ARB_RR_EN
          ptr_d     = winner;
`endif
        end
      end
      BUSY: begin
        // The memory cannot be cancelled, so a dropped request only suppresses the done pulse.
        if (!granted_en) abandon_d = 1'b1;
        if (bus.mem_rsp_in.done) begin
          data_d  = bus.mem_rsp_in.data;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      data_q    <= '0;
      abandon_q <= 1'b0;
`ifdef MEM_READ_ARB_RR_EN
      ptr_q     <= IDX_W'(CH_CNT - 1);
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      data_q    <= data_d;
      abandon_q <= abandon_d;
`ifdef MEM_READ_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  always_comb begin
    bus.mem_req_out = sys::mem_read_req_rst;
    if (state_q == BUSY) begin
      bus.mem_req_out.addr = addr_q;
      bus.mem_req_out.size = size_q;
      bus.mem_req_out.en   = 1'b1;
    end
    for (int j = 0; j < CH_CNT; j++) begin
      bus.rsp_out[j] = sys::mem_read_rsp_rst;
      if (state_q == RESP && IDX_W'(j) == grant_q && !abandon_q) begin
        bus.rsp_out[j].data = data_q;
        bus.rsp_out[j].done = 1'b1;
      end
    end
    bus.grant_idx = grant_q;
    bus.busy      = (state_q != IDLE);
  end

endmodule
